// File: rtl/ex_stage.sv
// Execute stage: ALU, store/link data select and an iterative 32-step multiply/divide
// unit with HI/LO. Every result is registered into the EX/MEM boundary.
package ex_stage_pkg;
   parameter int CONTROL_REG_SIZE = 16;
   parameter int LINK             = 5;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
      OP_XOR   = 5'd4,  OP_NOR   = 5'd5,  OP_SLT   = 5'd6,  OP_SLTU  = 5'd7,
      OP_SLL   = 5'd8,  OP_SRL   = 5'd9,  OP_SRA   = 5'd10, OP_LUI   = 5'd11,
      OP_MULT  = 5'd12, OP_MULTU = 5'd13, OP_DIV   = 5'd14, OP_DIVU  = 5'd15,
      OP_MFHI  = 5'd16, OP_MFLO  = 5'd17, OP_PASSB = 5'd18
   } alu_op_e;
endpackage

module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic [0:31]                   rs_val,
   input  logic [0:31]                   op_b,
   input  logic [0:31]                   rt_val,
   input  logic [0:31]                   pc_plus8,
   input  logic [0:4]                    shamt,
   input  logic [0:4]                    alu_op,
   input  logic [0:CONTROL_REG_SIZE-1]   control,
   input  logic [0:4]                    rdIn,
   output logic                          stall,
   output logic [0:31]                   address,
   output logic [0:31]                   data_out,
   output logic [0:CONTROL_REG_SIZE-1]   control_out,
   output logic [0:4]                    rdOut
);
   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

   // Ports use ascending ranges; work in descending form so bit 31 is the MSB.
   logic [31:0] a, b;
   logic [4:0]  sa;
   assign a  = rs_val;
   assign b  = op_b;
   assign sa = shamt;

   md_state_e   state_q;
   logic [4:0]  cnt_q;
   logic        is_div_q, neg_q, neg_rem_q, div0_q;
   logic [31:0] dvsr_q, hi_q, lo_q;
   logic [63:0] acc_q;

   logic        is_md, signed_op, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, quo, rem, hi_d, lo_d, result;
   logic [32:0] mul_sum, div_top, div_diff;
   logic [63:0] step_acc, prod;

   assign stall = (state_q != MD_IDLE) && (alu_op inside {[5'd12:5'd17]});

   always_comb begin
      is_md     = alu_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
      signed_op = (alu_op == OP_MULT) || (alu_op == OP_DIV);
      a_neg     = signed_op & a[31];
      b_neg     = signed_op & b[31];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;

      // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvsr_q} : 33'd0);
      div_top  = acc_q[63:31];
      div_diff = div_top - {1'b0, dvsr_q};
      step_acc = is_div_q ?
                 {(div_diff[32] ? div_top[31:0] : div_diff[31:0]), acc_q[30:0], ~div_diff[32]} :
                 {mul_sum, acc_q[31:1]};

      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[31:0] : acc_q[31:0];
      rem  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
      hi_d = is_div_q ? rem : prod[63:32];
      lo_d = is_div_q ? (div0_q ? '1 : quo) : prod[31:0];

      result = '0;
      case (alu_op)
         OP_ADD:   result = a + b;
         OP_SUB:   result = a - b;
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_NOR:   result = ~(a | b);
         OP_SLT:   result = {31'd0, $signed(a) < $signed(b)};
         OP_SLTU:  result = {31'd0, a < b};
         OP_SLL:   result = b << sa;
         OP_SRL:   result = b >> sa;
         OP_SRA:   result = $signed(b) >>> sa;
         OP_LUI:   result = {b[15:0], 16'h0000};
         OP_MFHI:  result = hi_q;
         OP_MFLO:  result = lo_q;
         OP_PASSB: result = b;
         default:  result = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= MD_IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         neg_q       <= 1'b0;
         neg_rem_q   <= 1'b0;
         div0_q      <= 1'b0;
         dvsr_q      <= '0;
         acc_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         address     <= '0;
         data_out    <= '0;
         control_out <= '0;
         rdOut       <= '0;
      end else begin
         if (stall) begin
            address     <= '0;
            data_out    <= '0;
            control_out <= '0;
            rdOut       <= '0;
         end else begin
            address     <= result;
            data_out    <= control[LINK] ? pc_plus8 : rt_val;
            control_out <= control;
            rdOut       <= rdIn;
         end

         case (state_q)
            MD_IDLE: if (is_md) begin
               is_div_q  <= (alu_op == OP_DIV) || (alu_op == OP_DIVU);
               neg_q     <= a_neg ^ b_neg;
               neg_rem_q <= a_neg;
               div0_q    <= (b == 32'd0);
               dvsr_q    <= b_mag;
               acc_q     <= {32'd0, a_mag};
               cnt_q     <= '0;
               state_q   <= MD_BUSY;
            end
            MD_BUSY: begin
               acc_q <= step_acc;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= MD_DONE;
            end
            MD_DONE: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               state_q <= MD_IDLE;
            end
            default: state_q <= MD_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed and randomized ALU and mult/div traffic
// checked against a cycle-timeline reference model of the stage.
`timescale 1ns/1ps
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic                        clock = 1'b0;
   logic                        reset;
   logic [0:31]                 rs_val, op_b, rt_val, pc_plus8;
   logic [0:4]                  shamt, alu_op, rdIn;
   logic [0:CONTROL_REG_SIZE-1] control;
   logic                        stall;
   logic [0:31]                 address, data_out;
   logic [0:CONTROL_REG_SIZE-1] control_out;
   logic [0:4]                  rdOut;

   ex_stage dut (
      .clock(clock), .reset(reset), .rs_val(rs_val), .op_b(op_b), .rt_val(rt_val),
      .pc_plus8(pc_plus8), .shamt(shamt), .alu_op(alu_op), .control(control),
      .rdIn(rdIn), .stall(stall), .address(address), .data_out(data_out),
      .control_out(control_out), .rdOut(rdOut)
   );

   always #5 clock = ~clock;

   int unsigned n_vec = 0, n_err = 0;

   // Reference model: unit is busy while cyc < idle_at; pending HI/LO land at pend_at.
   longint unsigned cyc = 0, idle_at = 0, pend_at = 0;
   bit                          pend_v = 1'b0;
   logic [31:0]                 m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic                        obs_stall, exp_stall;
   logic [31:0]                 exp_addr, exp_data;
   logic [CONTROL_REG_SIZE-1:0] exp_ctrl;
   logic [4:0]                  exp_rd;

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, b, input int s);
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return a & b;
         3:  return a | b;
         4:  return a ^ b;
         5:  return ~(a | b);
         6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         7:  return (a < b) ? 32'd1 : 32'd0;
         8:  return b << s;
         9:  return b >> s;
         10: return 32'($signed(b) >>> s);
         11: return {b[15:0], 16'h0000};
         16: return m_hi;
         17: return m_lo;
         18: return b;
         default: return 32'd0;
      endcase
   endfunction

   // Returns {HI, LO}.
   function automatic logic [63:0] ref_md(input int op, input logic [31:0] a, b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      p  = '0;
      case (op)
         12: p = sa * sb;
         13: p = {32'd0, a} * {32'd0, b};
         14: if (b == 32'd0) p = {a, 32'hFFFFFFFF};
             else begin
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
             end
         15: if (b == 32'd0) p = {a, 32'hFFFFFFFF};
             else p = {a % b, a / b};
         default: p = '0;
      endcase
      return p;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input int op, input logic [31:0] a, b);
      reset    = 1'b0;
      alu_op   = 5'(op);
      rs_val   = a;
      op_b     = b;
      rt_val   = $urandom;
      pc_plus8 = $urandom;
      shamt    = 5'($urandom_range(0, 31));
      control  = CONTROL_REG_SIZE'($urandom);
      rdIn     = 5'($urandom);
   endtask

   // Called at the falling edge with inputs applied; returns at the next falling edge.
   task automatic tick();
      int          op;
      logic [63:0] md;
      op = int'(alu_op);
      #1;
      obs_stall = stall;
      exp_stall = (cyc < idle_at) && (op >= 12) && (op <= 17);
      if (reset || exp_stall) begin
         exp_addr = '0; exp_data = '0; exp_ctrl = '0; exp_rd = '0;
      end else begin
         exp_addr = ref_alu(op, rs_val, op_b, int'(shamt));
         exp_data = control[LINK] ? pc_plus8 : rt_val;
         exp_ctrl = control;
         exp_rd   = rdIn;
         if (op >= 12 && op <= 15) begin
            md      = ref_md(op, rs_val, op_b);
            p_hi    = md[63:32];
            p_lo    = md[31:0];
            pend_v  = 1'b1;
            pend_at = cyc + 33;
            idle_at = cyc + 34;
         end
      end
      if (reset) begin
         m_hi = '0; m_lo = '0; pend_v = 1'b0; idle_at = 0;
      end else if (pend_v && cyc == pend_at) begin
         m_hi = p_hi; m_lo = p_lo; pend_v = 1'b0;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
   endtask

   // Present the current inputs until accepted; n = number of stalled cycles.
   task automatic issue_hold(output int n);
      n = 0;
      tick();
      while (obs_stall === 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      drive($urandom_range(0, 31), $urandom, $urandom);
      reset = 1'b1;
      tick();
      n_vec++;
      if ({address, data_out, control_out, rdOut} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h %h %h %h, expected all zero",
                  address, data_out, control_out, rdOut);
      end
      drive(16, $urandom, $urandom);
      reset = 1'b1;
      tick();
      n_vec++;
      if (obs_stall !== 1'b0 || address !== 32'd0) begin
         n_err++;
         $display("FAIL reset_stall: got stall=%b address=%h, expected 0/0", obs_stall, address);
      end
   endtask

   task automatic test_alu_directed();
      logic [31:0] ta[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
      logic [31:0] tb[5] = '{32'h00000001, 32'h0, 32'h0, 32'h80000000, 32'h00001234};
      int          to[5] = '{0, 6, 7, 10, 11};
      logic [31:0] te[5] = '{32'h80000000, 32'h1, 32'h0, 32'hF8000000, 32'h12340000};
      for (int i = 0; i < 5; i++) begin
         drive(to[i], ta[i], tb[i]);
         shamt = 5'd4;
         tick();
         n_vec++;
         if (address !== te[i] || obs_stall !== 1'b0) begin
            n_err++;
            $display("FAIL alu_directed[%0d]: got %h stall=%b, expected %h", i, address, obs_stall, te[i]);
         end
      end
      for (int k = 0; k < 2; k++) begin
         drive(0, 32'h1000, 32'h4);
         control[LINK] = (k == 0);
         pc_plus8 = 32'h00400010;
         rt_val   = 32'h0000DEAD;
         tick();
         n_vec++;
         if (data_out !== ((k == 0) ? 32'h00400010 : 32'h0000DEAD)) begin
            n_err++;
            $display("FAIL link_data[%0d]: got %h, expected %h", k, data_out,
                     (k == 0) ? 32'h00400010 : 32'h0000DEAD);
         end
      end
   endtask

   task automatic test_random_alu();
      int op;
      for (int i = 0; i < 150; i++) begin
         op = $urandom_range(0, 31);
         if (op >= 12 && op <= 15) op = op + 6;
         drive(op, pick(), pick());
         tick();
         n_vec++;
         if ({obs_stall, address, data_out, control_out, rdOut} !==
             {exp_stall, exp_addr, exp_data, exp_ctrl, exp_rd}) begin
            n_err++;
            $display("FAIL rand_alu[%0d] op=%0d: got %h, expected %h", i, op,
                     {obs_stall, address, data_out, control_out, rdOut},
                     {exp_stall, exp_addr, exp_data, exp_ctrl, exp_rd});
         end
      end
   endtask

   task automatic test_mult_stall();
      int n;
      drive(12, 32'hFFFFFFFD, 32'd7);
      tick();
      drive(17, $urandom, $urandom);
      n = 0;
      tick();
      while (obs_stall === 1'b1 && n < 100) begin
         n++;
         n_vec++;
         if ({address, data_out, control_out, rdOut} !== '0) begin
            n_err++;
            $display("FAIL mult_bubble[%0d]: got %h %h %h %h, expected all zero",
                     n, address, data_out, control_out, rdOut);
         end
         tick();
      end
      n_vec++;
      if (n != 33 || address !== 32'hFFFFFFEB) begin
         n_err++;
         $display("FAIL mult_mflo: got %0d stalls address=%h, expected 33 stalls address=ffffffeb",
                  n, address);
      end
      drive(16, $urandom, $urandom);
      tick();
      n_vec++;
      if (address !== 32'hFFFFFFFF || obs_stall !== 1'b0) begin
         n_err++;
         $display("FAIL mult_mfhi: got %h stall=%b, expected ffffffff", address, obs_stall);
      end
   endtask

   task automatic test_div();
      logic [31:0] da[2] = '{32'hFFFFFFF9, 32'd5};
      logic [31:0] db[2] = '{32'd2, 32'd0};
      int          dop[2] = '{14, 15};
      logic [31:0] elo[2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
      logic [31:0] ehi[2] = '{32'hFFFFFFFF, 32'd5};
      int          n;
      for (int i = 0; i < 2; i++) begin
         drive(dop[i], da[i], db[i]);
         tick();
         for (int j = 0; j < 4; j++) begin
            drive(0, $urandom, $urandom);
            tick();
            n_vec++;
            if (obs_stall !== 1'b0 || address !== exp_addr) begin
               n_err++;
               $display("FAIL add_mid_div[%0d.%0d]: got %h stall=%b, expected %h stall=0",
                        i, j, address, obs_stall, exp_addr);
            end
         end
         drive(17, $urandom, $urandom);
         issue_hold(n);
         n_vec++;
         if (address !== elo[i] || n > 40) begin
            n_err++;
            $display("FAIL div_lo[%0d]: got %h after %0d stalls, expected %h", i, address, n, elo[i]);
         end
         drive(16, $urandom, $urandom);
         tick();
         n_vec++;
         if (address !== ehi[i]) begin
            n_err++;
            $display("FAIL div_hi[%0d]: got %h, expected %h", i, address, ehi[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int exp_n[3] = '{33, 33, 0};
      for (int i = 0; i < 8; i++) begin
         drive($urandom_range(12, 15), pick(), pick());
         tick();
         n_vec++;
         if ({obs_stall, address, data_out, control_out, rdOut} !==
             {exp_stall, exp_addr, exp_data, exp_ctrl, exp_rd}) begin
            n_err++;
            $display("FAIL b2b_first[%0d]: got %h, expected %h", i,
                     {obs_stall, address, data_out, control_out, rdOut},
                     {exp_stall, exp_addr, exp_data, exp_ctrl, exp_rd});
         end
         for (int k = 0; k < 3; k++) begin
            drive((k == 0) ? int'($urandom_range(12, 15)) : 15 + k, pick(), pick());
            issue_hold(n);
            n_vec++;
            if (n != exp_n[k] || {address, data_out, control_out, rdOut} !==
                {exp_addr, exp_data, exp_ctrl, exp_rd}) begin
               n_err++;
               $display("FAIL b2b[%0d.%0d]: got %0d stalls %h, expected %0d stalls %h", i, k, n,
                        {address, data_out, control_out, rdOut}, exp_n[k],
                        {exp_addr, exp_data, exp_ctrl, exp_rd});
            end
         end
      end
   endtask

   task automatic test_reset_busy();
      drive(13, $urandom, $urandom | 32'h1);
      tick();
      for (int j = 0; j < 9; j++) begin
         drive(0, $urandom, $urandom);
         tick();
         n_vec++;
         if (obs_stall !== 1'b0 || address !== exp_addr) begin
            n_err++;
            $display("FAIL add_mid_mul[%0d]: got %h stall=%b, expected %h", j, address, obs_stall, exp_addr);
         end
      end
      drive(16, $urandom, $urandom);
      reset = 1'b1;
      tick();
      drive(16, $urandom, $urandom);
      rt_val  = '0;
      control = '0;
      rdIn    = '0;
      tick();
      n_vec++;
      if (obs_stall !== 1'b0 || {address, data_out, control_out, rdOut} !== '0) begin
         n_err++;
         $display("FAIL reset_busy: got stall=%b %h %h %h %h, expected stall=0 all zero",
                  obs_stall, address, data_out, control_out, rdOut);
      end
      drive(17, $urandom, $urandom);
      tick();
      n_vec++;
      if (obs_stall !== 1'b0 || address !== 32'd0) begin
         n_err++;
         $display("FAIL reset_busy_lo: got stall=%b address=%h, expected 0/0", obs_stall, address);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

   initial begin
      drive(0, '0, '0);
      reset = 1'b1;
      @(negedge clock);
      test_reset();
      test_alu_directed();
      test_random_alu();
      test_mult_stall();
      test_div();
      test_back_to_back();
      test_reset_busy();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
